// File: rtl/test_pattern_gen.sv
// test_pattern_gen: self-starting frame-buffer filler.
// After reset it writes one test frame (colour bars on top, checkerboard
// below) into the frame buffer, one pixel per clock, then goes quiet.
// Optional build macro TPG_ANIMATE_EN: after an idle frame-time the fill
// repeats with the bars rotated by a 3-bit frame counter.
// All raster state is kept in incremental counters; no multiply/divide.
module test_pattern_gen #(
    parameter int FRAME_WIDTH     = 160,
    parameter int FRAME_HEIGHT    = 120,
    parameter int SCALING_FACTOR  = 4,
    parameter int FBUF_ADDR_WIDTH = 16,
    parameter int FBUF_DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [FBUF_ADDR_WIDTH-1:0] pixel_fbuf_address,
    output logic [FBUF_DATA_WIDTH-1:0] pixel_fbuf_color,
    output logic                       pixel_fbuf_wr_en
);

    localparam int XW    = (FRAME_WIDTH    > 1) ? $clog2(FRAME_WIDTH)    : 1;
    localparam int YW    = (FRAME_HEIGHT   > 1) ? $clog2(FRAME_HEIGHT)   : 1;
    localparam int SW    = (SCALING_FACTOR > 1) ? $clog2(SCALING_FACTOR) : 1;
    localparam int AW    = FBUF_ADDR_WIDTH;
    localparam int DW    = FBUF_DATA_WIDTH;
    localparam int BAR_W = FRAME_WIDTH / 8;
`ifdef TPG_ANIMATE_EN
    localparam int NPIX  = FRAME_WIDTH * FRAME_HEIGHT;
`endif

    typedef enum logic [1:0] {S_RESET, S_FILL, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;        // current column
    logic [YW-1:0]   y_q, y_d;        // current line
    logic [AW-1:0]   addr_q, addr_d;  // linear pixel address
    logic [2:0]      bar_q, bar_d;    // bar index, saturates at 7
    logic [XW-1:0]   bcnt_q, bcnt_d;  // position inside current bar
    logic [SW-1:0]   cx_q, cx_d;      // position inside checker cell (x)
    logic [SW-1:0]   cy_q, cy_d;      // position inside checker cell (y)
    logic            px_q, px_d;      // bit 0 of x/SCALING_FACTOR
    logic            py_q, py_d;      // bit 0 of y/SCALING_FACTOR
    logic            bot_q, bot_d;    // y is in the checkerboard half

    logic [AW-1:0]   out_addr_q, out_addr_d;
    logic [DW-1:0]   out_color_q, out_color_d;
    logic            out_wr_q, out_wr_d;

    logic [2:0]      bar_idx;
    logic [7:0]      rgb;
    logic [DW-1:0]   pix_color;

`ifdef TPG_ANIMATE_EN
    logic [2:0]      frame_q, frame_d;  // bar rotation per repeated frame
    logic [AW-1:0]   idle_q, idle_d;    // idle cycles spent in DONE
`endif

    // Colour of the pixel at the current raster position
    always_comb begin
`ifdef TPG_ANIMATE_EN
        bar_idx = bar_q + frame_q;
`else
        bar_idx = bar_q;
`endif
        case (bar_idx)
            3'd0:    rgb = 8'hFF;  // white
            3'd1:    rgb = 8'hFC;  // yellow
            3'd2:    rgb = 8'h1F;  // cyan
            3'd3:    rgb = 8'h1C;  // green
            3'd4:    rgb = 8'hE3;  // magenta
            3'd5:    rgb = 8'hE0;  // red
            3'd6:    rgb = 8'h03;  // blue
            default: rgb = 8'h00;  // black
        endcase
        if (bot_q) rgb = (px_q ^ py_q) ? 8'hFF : 8'h00;
        pix_color = DW'(rgb);
    end

    // Next-state: raster walk during fill, quiet (or idle count) when done
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        bar_d       = bar_q;
        bcnt_d      = bcnt_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        px_d        = px_q;
        py_d        = py_q;
        bot_d       = bot_q;
        out_addr_d  = '0;
        out_color_d = '0;
        out_wr_d    = 1'b0;
`ifdef TPG_ANIMATE_EN
        frame_d     = frame_q;
        idle_d      = idle_q;
`endif
        case (state_q)
            S_RESET, S_FILL: begin
                // the first edge out of reset already presents pixel (0,0)
                state_d     = S_FILL;
                out_wr_d    = 1'b1;
                out_addr_d  = addr_q;
                out_color_d = pix_color;
                addr_d      = addr_q + AW'(1);
                if (x_q == XW'(FRAME_WIDTH - 1)) begin
                    x_d    = '0;
                    bar_d  = '0;
                    bcnt_d = '0;
                    cx_d   = '0;
                    px_d   = 1'b0;
                    if (y_q == YW'(FRAME_HEIGHT - 1)) begin
                        // last pixel: rewind everything for a possible repeat
                        y_d     = '0;
                        cy_d    = '0;
                        py_d    = 1'b0;
                        bot_d   = 1'b0;
                        addr_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        y_d = y_q + YW'(1);
                        if (y_q == YW'(FRAME_HEIGHT / 2 - 1)) bot_d = 1'b1;
                        if (cy_q == SW'(SCALING_FACTOR - 1)) begin
                            cy_d = '0;
                            py_d = ~py_q;
                        end else begin
                            cy_d = cy_q + SW'(1);
                        end
                    end
                end else begin
                    x_d = x_q + XW'(1);
                    // the last bar absorbs any remainder columns
                    if (bar_q != 3'd7) begin
                        if (bcnt_q == XW'(BAR_W - 1)) begin
                            bcnt_d = '0;
                            bar_d  = bar_q + 3'd1;
                        end else begin
                            bcnt_d = bcnt_q + XW'(1);
                        end
                    end
                    if (cx_q == SW'(SCALING_FACTOR - 1)) begin
                        cx_d = '0;
                        px_d = ~px_q;
                    end else begin
                        cx_d = cx_q + SW'(1);
                    end
                end
            end
            S_DONE: begin
`ifdef TPG_ANIMATE_EN
                // one frame-time of silence, then fill again with bars rotated
                if (idle_q == AW'(NPIX - 1)) begin
                    idle_d  = '0;
                    frame_d = frame_q + 3'd1;
                    state_d = S_FILL;
                end else begin
                    idle_d = idle_q + AW'(1);
                end
`endif
            end
            default: state_d = S_RESET;
        endcase
    end

    // State and registered outputs; everything clears while reset is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            bar_q       <= '0;
            bcnt_q      <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            px_q        <= 1'b0;
            py_q        <= 1'b0;
            bot_q       <= 1'b0;
            out_addr_q  <= '0;
            out_color_q <= '0;
            out_wr_q    <= 1'b0;
`ifdef TPG_ANIMATE_EN
            frame_q     <= '0;
            idle_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            bar_q       <= bar_d;
            bcnt_q      <= bcnt_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            px_q        <= px_d;
            py_q        <= py_d;
            bot_q       <= bot_d;
            out_addr_q  <= out_addr_d;
            out_color_q <= out_color_d;
            out_wr_q    <= out_wr_d;
`ifdef TPG_ANIMATE_EN
            frame_q     <= frame_d;
            idle_q      <= idle_d;
`endif
        end
    end

    assign pixel_fbuf_address = out_addr_q;
    assign pixel_fbuf_color   = out_color_q;
    assign pixel_fbuf_wr_en   = out_wr_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: captures a whole frame, then checks a table
// of hand-computed (address, colour) points plus reset/frame-end sequences.
module tb_test_pattern_gen;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  color;
    logic        wr_en;

    always #5 clk = ~clk;

    test_pattern_gen #(
        .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .SCALING_FACTOR(4),
        .FBUF_ADDR_WIDTH(16), .FBUF_DATA_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pixel_fbuf_address(addr), .pixel_fbuf_color(color),
        .pixel_fbuf_wr_en(wr_en)
    );

`ifdef TPG_ANIMATE_EN
    logic        rst_small_n;
    logic [15:0] s_addr;
    logic [7:0]  s_color;
    logic        s_wr;

    test_pattern_gen #(
        .FRAME_WIDTH(16), .FRAME_HEIGHT(8), .SCALING_FACTOR(2),
        .FBUF_ADDR_WIDTH(16), .FBUF_DATA_WIDTH(8)
    ) dut_small (
        .clk(clk), .rst_n(rst_small_n),
        .pixel_fbuf_address(s_addr), .pixel_fbuf_color(s_color),
        .pixel_fbuf_wr_en(s_wr)
    );
`endif

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int    addr;
        int    color;
        string name;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] cap [NPIX];

    task automatic add(input int a, input int c, input string n);
        vec_t v;
        v.addr = a; v.color = c; v.name = n;
        tbl.push_back(v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr, last, bad, cnt;

        // expected pixels, hand-computed for 160x120, BAR_W=20, cell 4
        add(0,     8'hFF, "bar0_first");
        add(19,    8'hFF, "bar0_last");
        add(20,    8'hFC, "bar1_first");
        add(40,    8'h1F, "bar2");
        add(60,    8'h1C, "bar3");
        add(80,    8'hE3, "bar4");
        add(100,   8'hE0, "bar5");
        add(139,   8'h03, "bar6_last");
        add(140,   8'h00, "bar7_first");
        add(159,   8'h00, "line0_end");
        add(160,   8'hFF, "line1_start");
        add(9599,  8'h00, "y59_end");
        add(9600,  8'hFF, "chk_x0_y60");
        add(9601,  8'hFF, "chk_x1_y60");
        add(9604,  8'h00, "chk_x4_y60");
        add(9760,  8'hFF, "chk_x0_y61");
        add(10240, 8'h00, "chk_x0_y64");
        add(10244, 8'hFF, "chk_x4_y64");
        add(19199, 8'h00, "last_pixel");

`ifdef TPG_ANIMATE_EN
        rst_small_n = 1'b0;
`endif
        // reset hold
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr",  int'(addr),  0);
        chk("rst_color", int'(color), 0);
        chk("rst_wr",    int'(wr_en), 0);

        // release and walk the whole frame
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_wr",    int'(wr_en), 1);
        chk("first_addr",  int'(addr),  0);
        chk("first_color", int'(color), 8'hFF);
        cap[0] = color;
        nwr = 1; last = int'(addr); bad = 0;
        for (int c = 0; c < NPIX + 10; c++) begin
            @(negedge clk);
            if (!wr_en) break;
            if (int'(addr) != nwr) bad++;
            if (nwr < NPIX) cap[nwr] = color;
            last = int'(addr);
            nwr++;
        end
        chk("wr_count",    nwr,  NPIX);
        chk("consecutive", bad,  0);
        chk("last_addr",   last, NPIX - 1);
        chk("done_wr",     int'(wr_en), 0);
        chk("done_addr",   int'(addr),  0);
        chk("done_color",  int'(color), 0);

        for (int i = 0; i < tbl.size(); i++)
            chk(tbl[i].name, int'(cap[tbl[i].addr]), tbl[i].color);

        // quiet after the frame
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (wr_en || addr != 0 || color != 0) bad++;
        end
        chk("done_hold", bad, 0);

        // restart, then pulse reset mid-fill at write 1000
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (wr_en && addr == 16'd1000) break;
        end
        chk("reach_1000", int'(addr), 1000);
        #2 rst_n = 1'b0;
        #1;
        chk("async_addr",  int'(addr),  0);
        chk("async_color", int'(color), 0);
        chk("async_wr",    int'(wr_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_wr",    int'(wr_en), 1);
        chk("restart_addr",  int'(addr),  0);
        chk("restart_color", int'(color), 8'hFF);
        @(negedge clk);
        chk("restart_addr1", int'(addr),  1);

`ifdef TPG_ANIMATE_EN
        // small frame: 128 writes, 128 idle, then rotated bars
        @(negedge clk);
        rst_small_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (s_wr) cnt++;
            else if (cnt > 0) break;
        end
        chk("anim_writes", cnt, 128);
        nwr = 1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (s_wr) break;
            nwr++;
        end
        chk("anim_idle",   nwr, 128);
        chk("anim2_wr",    int'(s_wr),    1);
        chk("anim2_addr",  int'(s_addr),  0);
        chk("anim2_color", int'(s_color), 8'hFC);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/test_pattern_gen.md
# test_pattern_gen

Self-starting frame-buffer filler: after reset it writes a fixed test image into the pixel frame buffer, one pixel per clock, then goes quiet. It sits in front of the frame-buffer write port and gives the video path a known image before any real pixel source is attached. The image has colour bars in the top half and a checkerboard in the bottom half, with checker cell size set by SCALING_FACTOR.

## Interface
- FRAME_WIDTH, 160: pixels per line (x range 0..FRAME_WIDTH-1).
- FRAME_HEIGHT, 120: lines per frame.
- SCALING_FACTOR, 4: checkerboard cell edge in pixels, ≥1.
- FBUF_ADDR_WIDTH, 16: address width; FRAME_WIDTH*FRAME_HEIGHT ≤ 2^FBUF_ADDR_WIDTH.
- FBUF_DATA_WIDTH, 8: colour width, ≥8. Colour is RGB332 in bits [7:0], and upper bits are zero.
- clk  in  1  the single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- pixel_fbuf_address  out  FBUF_ADDR_WIDTH  write address, y*FRAME_WIDTH + x.
- pixel_fbuf_color  out  FBUF_DATA_WIDTH  write data.
- pixel_fbuf_wr_en  out  1  write strobe, one write per high cycle, no back-pressure.

## Operation
- States: RESET (rst_n low), FILL, DONE.
- RESET → FILL on the first rising edge with rst_n high.
- FILL → DONE after pixel FRAME_WIDTH*FRAME_HEIGHT-1 has been presented.
- DONE is terminal unless TPG_ANIMATE_EN is defined.
- FILL scan order: raster, x fastest, starting at (0,0). The address counter increments by 1 per cycle.
- x, y, bar index and checker sub-counters are maintained incrementally. No multipliers or dividers.
- Top half (y < FRAME_HEIGHT/2), colour bars:
  - BAR_W = FRAME_WIDTH/8 (integer division); bar index = x/BAR_W, clamped to 7.
  - Colours for bars 0..7: 0xFF white, 0xFC yellow, 0x1F cyan, 0x1C green, 0xE3 magenta, 0xE0 red, 0x03 blue, 0x00 black.
- Bottom half (y ≥ FRAME_HEIGHT/2), checkerboard:
  - Colour = 0xFF when ((x/SCALING_FACTOR) xor (y/SCALING_FACTOR)) bit 0 = 1; otherwise 0x00.
  - Cells are aligned to absolute (0,0), not to the half boundary.
- DONE: wr_en = 0, address = 0, colour = 0.

## Timing
- Outputs are registered.
- During rst_n low, outputs are asynchronously 0 (address 0, colour 0, wr_en 0).
- Edge 1 after reset release: address 0, colour = pixel(0,0), wr_en = 1.
- Edge k (1-based, in FILL): address k-1, colour = pixel(k-1).
- wr_en stays high for exactly FRAME_WIDTH*FRAME_HEIGHT consecutive cycles, with no gaps.
- Line wrap: x = FRAME_WIDTH-1 → x = 0, y+1, with no bubble cycle.
- The cycle after the last pixel: wr_en = 0 (DONE).
- rst_n asserted mid-fill: outputs clear immediately. On release the fill restarts from address 0.

## Configuration
- TPG_ANIMATE_EN defined:
  - DONE holds for FRAME_WIDTH*FRAME_HEIGHT idle cycles, then re-enters FILL.
  - A 3-bit frame counter increments on each re-entry. Bar colour index = (bar + frame) mod 8, so the bars scroll.
  - Checkerboard is unchanged. Frame counter resets to 0.
- TPG_ANIMATE_EN undefined: single fill, then DONE forever. No frame counter or idle counter is built.

## Test plan
- Reset hold, then release at defaults → outputs 0/0/0 during reset; first write has address 0, colour 0xFF, wr_en 1.
- Top-half bars, 160×120 → address 19 colour 0xFF, address 20 colour 0xFC, address 159 colour 0x00, address 160 colour 0xFF; addresses strictly consecutive.
- Bottom-half checkerboard, SCALING_FACTOR 4 → address 9600 (x0,y60) colour 0xFF, address 9604 colour 0x00, address 9760 (y61) colour 0xFF, address 10240 (y64) colour 0x00.
- Frame end → exactly 19200 wr_en cycles; last address 19199. Next cycle wr_en 0, address 0, colour 0, and they stay there (macro off).
- Reset pulse at write 1000 → outputs clear asynchronously; after release, writes restart at address 0 with colour 0xFF.
- TPG_ANIMATE_EN, with the small frame 16×8, SCALING_FACTOR 2 → 128 writes, 128 idle cycles, second frame address 0 colour 0xFC.
